// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : CPU pipeline stage register (payload + write-select + write-enable)
//            with valid/ready handshake, 2-entry skid buffer and flush.
// Options  : PIPE_STALL_CNT_EN - when defined, stall_count counts cycles where
//            the head entry is held by downstream backpressure (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_wsel,
  input  logic              in_wen,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_wsel,
  output logic              out_wen,
  output logic [31:0]       stall_count
);

  localparam logic [1:0] C_EMPTY = 2'd0;
  localparam logic [1:0] C_ONE   = 2'd1;
  localparam logic [1:0] C_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0]  main_wsel_q, main_wsel_d;
  logic              main_wen_q, main_wen_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_wsel_q, skid_wsel_d;
  logic              skid_wen_q, skid_wen_d;

  logic w_accept;
  logic w_release;

  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  // State and entry registers; reset clears everything, inputs ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= C_EMPTY;
      main_data_q <= '0;
      main_wsel_q <= '0;
      main_wen_q  <= 1'b0;
      skid_data_q <= '0;
      skid_wsel_q <= '0;
      skid_wen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_wsel_q <= main_wsel_d;
      main_wen_q  <= main_wen_d;
      skid_data_q <= skid_data_d;
      skid_wsel_q <= skid_wsel_d;
      skid_wen_q  <= skid_wen_d;
    end
  end

  // Next state and entry moves; flush squashes both entries and drops any
  // same-cycle accept/release (stale data is harmless since out_valid = 0).
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_wsel_d = main_wsel_q;
    main_wen_d  = main_wen_q;
    skid_data_d = skid_data_q;
    skid_wsel_d = skid_wsel_q;
    skid_wen_d  = skid_wen_q;
    if (flush) begin
      state_d = C_EMPTY;
    end else begin
      case (state_q)
        C_EMPTY: begin
          if (w_accept) begin
            state_d     = C_ONE;
            main_data_d = in_data;
            main_wsel_d = in_wsel;
            main_wen_d  = in_wen;
          end
        end
        C_ONE: begin
          if (w_accept && !w_release) begin
            // Head is stalled: the newcomer parks in the skid entry.
            state_d     = C_TWO;
            skid_data_d = in_data;
            skid_wsel_d = in_wsel;
            skid_wen_d  = in_wen;
          end else if (!w_accept && w_release) begin
            state_d = C_EMPTY;
          end else if (w_accept && w_release) begin
            main_data_d = in_data;
            main_wsel_d = in_wsel;
            main_wen_d  = in_wen;
          end
        end
        C_TWO: begin
          // in_ready is low here, so only a release can happen.
          if (w_release) begin
            state_d     = C_ONE;
            main_data_d = skid_data_q;
            main_wsel_d = skid_wsel_q;
            main_wen_d  = skid_wen_q;
          end
        end
        default: state_d = C_EMPTY;
      endcase
    end
  end

  // Handshake outputs depend on state only, so in_ready never combinationally
  // follows out_ready.
  always_comb begin
    in_ready  = (state_q != C_TWO);
    out_valid = (state_q != C_EMPTY);
    out_data  = main_data_q;
    out_wsel  = main_wsel_q;
    out_wen   = main_wen_q & (state_q != C_EMPTY);
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles the head entry waits on downstream.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg: directed vector table,
//            hand-written stall-counter sequence, randomized run against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_wen, flush;
  logic          out_valid, out_ready, out_wen;
  logic [DW-1:0] in_data, out_data;
  logic [SW-1:0] in_wsel, out_wsel;
  logic [31:0]   stall_count;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_wsel(in_wsel), .in_wen(in_wen), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wsel(out_wsel), .out_wen(out_wen), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] d,
                       input logic [4:0] ws, input logic we, input logic fl,
                       input logic ordy);
    rst = r; in_valid = iv; in_data = d; in_wsel = ws; in_wen = we;
    flush = fl; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_stall(input int unsigned n);
`ifdef PIPE_STALL_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  typedef struct {
    logic        r, iv;
    logic [31:0] d;
    logic [4:0]  ws;
    logic        we, fl, ordy;
    logic        ev, er, cd;
    logic [31:0] ed;
    logic [4:0]  ews;
    logic        ewe;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                              input logic [4:0] ws, input logic we, input logic fl,
                              input logic ordy, input logic ev, input logic er,
                              input logic cd, input logic [31:0] ed,
                              input logic [4:0] ews, input logic ewe);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.ws = ws; v.we = we; v.fl = fl; v.ordy = ordy;
    v.ev = ev; v.er = er; v.cd = cd; v.ed = ed; v.ews = ews; v.ewe = ewe;
    return v;
  endfunction

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;

  vec_t vt[20];

  // Reference model: a FIFO of at most two entries.
  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  ws;
    logic        we;
  } ent_t;
  ent_t        mq[$];
  int unsigned m_stall;

  initial begin
    //               r  iv d  ws  we fl or  ev er cd ed  ews we
    vt[0]  = mk(1, 1, C, 5'd3, 1, 0, 1,  0, 1, 1, 0, 5'd0, 0);
    vt[1]  = mk(0, 1, 1, 5'd1, 1, 0, 1,  1, 1, 1, 1, 5'd1, 1);
    vt[2]  = mk(0, 1, 2, 5'd2, 1, 0, 1,  1, 1, 1, 2, 5'd2, 1);
    vt[3]  = mk(0, 1, 3, 5'd3, 0, 0, 1,  1, 1, 1, 3, 5'd3, 0);
    vt[4]  = mk(0, 1, 4, 5'd4, 1, 0, 1,  1, 1, 1, 4, 5'd4, 1);
    vt[5]  = mk(0, 0, 9, 5'd9, 1, 0, 1,  0, 1, 0, 0, 5'd0, 0);
    vt[6]  = mk(0, 1, A, 5'd1, 1, 0, 0,  1, 1, 1, A, 5'd1, 1);
    vt[7]  = mk(0, 1, B, 5'd2, 1, 0, 0,  1, 0, 1, A, 5'd1, 1);
    vt[8]  = mk(0, 0, C, 5'd3, 1, 0, 0,  1, 0, 1, A, 5'd1, 1);
    vt[9]  = mk(0, 0, C, 5'd3, 1, 0, 1,  1, 1, 1, B, 5'd2, 1);
    vt[10] = mk(0, 0, C, 5'd3, 1, 0, 1,  0, 1, 0, 0, 5'd0, 0);
    vt[11] = mk(0, 1, A, 5'd1, 1, 0, 0,  1, 1, 1, A, 5'd1, 1);
    vt[12] = mk(0, 1, B, 5'd2, 1, 0, 0,  1, 0, 1, A, 5'd1, 1);
    vt[13] = mk(0, 1, C, 5'd3, 1, 1, 0,  0, 1, 0, 0, 5'd0, 0);
    vt[14] = mk(0, 0, C, 5'd3, 1, 0, 1,  0, 1, 0, 0, 5'd0, 0);
    vt[15] = mk(0, 1, 5, 5'd7, 1, 0, 0,  1, 1, 1, 5, 5'd7, 1);
    vt[16] = mk(0, 0, 6, 5'd2, 1, 0, 1,  0, 1, 1, 5, 5'd7, 0);
    vt[17] = mk(0, 1, A, 5'd1, 1, 0, 0,  1, 1, 1, A, 5'd1, 1);
    vt[18] = mk(0, 1, B, 5'd2, 1, 0, 0,  1, 0, 1, A, 5'd1, 1);
    vt[19] = mk(1, 1, C, 5'd3, 1, 0, 0,  0, 1, 1, 0, 5'd0, 0);

    drive(1, 0, 0, 0, 0, 0, 0);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].r, vt[i].iv, vt[i].d, vt[i].ws, vt[i].we, vt[i].fl, vt[i].ordy);
      tick();
      chk($sformatf("vec%0d out_valid", i), out_valid, vt[i].ev);
      chk($sformatf("vec%0d in_ready", i), in_ready, vt[i].er);
      chk($sformatf("vec%0d out_wen", i), out_wen, vt[i].ewe);
      if (vt[i].cd) begin
        chk($sformatf("vec%0d out_data", i), out_data, vt[i].ed);
        chk($sformatf("vec%0d out_wsel", i), out_wsel, vt[i].ews);
      end
      if (i == 0 || i == 19) chk($sformatf("vec%0d stall_count", i), stall_count, 32'd0);
    end

    // Stall counter: one entry held for 10 backpressured cycles
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h1234_5678, 5'd9, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("stall10 stall_count", stall_count, exp_stall(10));
    chk("stall10 out_data held", out_data, 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("stall flush no count", stall_count, exp_stall(10));
    chk("stall flush out_valid", out_valid, 1'b0);

    // Randomized run against the FIFO model
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, iv, fl, ordy, acc, rel;
      r    = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      drive(r, iv, $urandom, 5'($urandom), 1'($urandom), fl, ordy);
      acc = iv && (mq.size() < 2);
      rel = (mq.size() > 0) && ordy;
      tick();
      if (r) begin
        mq.delete();
        m_stall = 0;
      end else begin
        if (mq.size() > 0 && !ordy && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) mq.delete();
        else begin
          if (rel) void'(mq.pop_front());
          if (acc) mq.push_back({in_data, in_wsel, in_wen});
        end
      end
      chk("rnd out_valid", out_valid, mq.size() > 0);
      chk("rnd in_ready", in_ready, mq.size() < 2);
      chk("rnd stall_count", stall_count, exp_stall(m_stall));
      if (mq.size() > 0) begin
        chk("rnd out_data", out_data, mq[0].d);
        chk("rnd out_wsel", out_wsel, mq[0].ws);
        chk("rnd out_wen", out_wen, mq[0].we);
      end else begin
        chk("rnd out_wen idle", out_wen, 1'b0);
      end
      if (r) chk("rnd reset out_data", out_data, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
